// File: rtl/gpr_exec_unit_pkg.sv
// Shared definitions for the execute stage: instruction layout, opcodes, flag layout, FSM states.
package gpr_exec_unit_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned FLAGS_W   = 4;

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;

    // rsrc2 overlays isrc[15:11] in register mode
    typedef struct packed {
        logic [4:0]  oper_type;
        logic [4:0]  rdst;
        logic [4:0]  rsrc1;
        logic        imm_mode;
        logic [15:0] isrc;
    } instr_t;

    typedef struct packed {
        logic sign;
        logic zero;
        logic carry;
        logic ovf;
    } flags_t;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

endpackage

// File: rtl/gpr_exec_unit_seq_multiplier.sv
// Radix-2 shift-add multiplier: one step per clock, DATA_W steps after start.
// done_c/product_c flag the final step combinationally so the caller can commit at that same edge.
module gpr_exec_unit_seq_multiplier #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done_c,
    output logic [2*DATA_W-1:0]   product_c
);
    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] acc;
    logic [CNT_W-1:0]    count;
    logic [DATA_W:0]     sum;

    // acc holds {partial high, remaining multiplier bits}; each step adds and shifts right
    always_comb begin
        sum       = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);
        product_c = {sum, acc[DATA_W-1:1]};
        done_c    = busy && (count == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            mcand <= '0;
            acc   <= '0;
            count <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            mcand <= a;
            acc   <= {DATA_W'(0), b};
            count <= '0;
        end else if (busy) begin
            acc   <= product_c;
            count <= count + CNT_W'(1);
            if (done_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gpr_exec_unit.sv
// Execute stage: GPR file, MOV/ADD/SUB/MUL datapath with a valid/ready issue handshake.
// Define EXEC_FLAGS_EN to build the {sign, zero, carry, overflow} flags register; otherwise flags = 0.
module gpr_exec_unit
    import gpr_exec_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_GPR = 32
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [INSTR_W-1:0]   instr,
    output logic                 done,
    output logic                 illegal,
    output logic [DATA_W-1:0]    sgpr,
    output logic [FLAGS_W-1:0]   flags,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]    dbg_data
);
    localparam int unsigned IDX_W = $clog2(NUM_GPR);
    localparam int unsigned CMP_W = REG_IDX_W + 1;

    instr_t               ins;
    state_t               state, state_next;
    logic [DATA_W-1:0]    gpr [NUM_GPR];
    logic [DATA_W-1:0]    op_a, op_b, alu_sum, alu_diff, wr_data, sgpr_next;
    logic [REG_IDX_W-1:0] rsrc2, wr_idx, mul_rdst;
    logic                 wr_en, sgpr_en, done_next, illegal_next, accept;
    logic                 mul_start, mul_busy, mul_done_c;
    logic [2*DATA_W-1:0]  mul_product_c;

    function automatic logic in_range(input logic [REG_IDX_W-1:0] idx);
        return {1'b0, idx} < CMP_W'(NUM_GPR);
    endfunction

    assign ins      = instr;
    assign rsrc2    = ins.isrc[15:11];
    assign accept   = instr_valid && instr_ready && !mul_busy;
    assign alu_sum  = op_a + op_b;
    assign alu_diff = op_a - op_b;

    // Register-file reads; out-of-range indices read as zero
    always_comb begin
        op_a     = '0;
        op_b     = DATA_W'(ins.isrc);
        dbg_data = '0;
        if (in_range(ins.rsrc1)) op_a = gpr[ins.rsrc1[IDX_W-1:0]];
        if (!ins.imm_mode) op_b = in_range(rsrc2) ? gpr[rsrc2[IDX_W-1:0]] : '0;
        if (in_range(dbg_addr)) dbg_data = gpr[dbg_addr[IDX_W-1:0]];
    end

    always_comb begin
        state_next   = state;
        wr_en        = 1'b0;
        wr_idx       = ins.rdst;
        wr_data      = '0;
        sgpr_en      = 1'b0;
        sgpr_next    = sgpr;
        done_next    = 1'b0;
        illegal_next = 1'b0;
        mul_start    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    done_next = 1'b1;
                    case (ins.oper_type)
                        OP_MOVSGPR: begin wr_en = 1'b1; wr_data = sgpr;     end
                        OP_MOV:     begin wr_en = 1'b1; wr_data = op_b;     end
                        OP_ADD:     begin wr_en = 1'b1; wr_data = alu_sum;  end
                        OP_SUB:     begin wr_en = 1'b1; wr_data = alu_diff; end
                        OP_MUL: begin
                            done_next  = 1'b0;
                            mul_start  = 1'b1;
                            state_next = ST_MUL;
                        end
                        default: illegal_next = 1'b1;
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_done_c) begin
                    wr_en      = 1'b1;
                    wr_idx     = mul_rdst;
                    wr_data    = mul_product_c[DATA_W-1:0];
                    sgpr_en    = 1'b1;
                    sgpr_next  = mul_product_c[2*DATA_W-1:DATA_W];
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            instr_ready <= 1'b1;
            done        <= 1'b0;
            illegal     <= 1'b0;
            sgpr        <= '0;
            mul_rdst    <= '0;
            for (int unsigned i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
        end else begin
            state       <= state_next;
            instr_ready <= (state_next == ST_IDLE);
            done        <= done_next;
            illegal     <= illegal_next;
            if (sgpr_en) sgpr <= sgpr_next;
            if (mul_start) mul_rdst <= ins.rdst;
            if (wr_en && in_range(wr_idx)) gpr[wr_idx[IDX_W-1:0]] <= wr_data;
        end
    end

    gpr_exec_unit_seq_multiplier #(.DATA_W(DATA_W)) u_mul (
        .clk       (clk),
        .rst       (sys_rst),
        .start     (mul_start),
        .a         (op_a),
        .b         (op_b),
        .busy      (mul_busy),
        .done_c    (mul_done_c),
        .product_c (mul_product_c)
    );

`ifdef EXEC_FLAGS_EN
    flags_t            flags_q, flags_d;
    logic [DATA_W-1:0] mul_lo, mul_hi;

    // ADD/SUB update at accept, MUL at its final step; everything else holds
    always_comb begin
        flags_d = flags_q;
        mul_lo  = mul_product_c[DATA_W-1:0];
        mul_hi  = mul_product_c[2*DATA_W-1:DATA_W];
        if (accept && ins.oper_type == OP_ADD) begin
            flags_d.sign  = alu_sum[DATA_W-1];
            flags_d.zero  = (alu_sum == '0);
            flags_d.carry = (alu_sum < op_a);
            flags_d.ovf   = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (alu_sum[DATA_W-1] != op_a[DATA_W-1]);
        end else if (accept && ins.oper_type == OP_SUB) begin
            flags_d.sign  = alu_diff[DATA_W-1];
            flags_d.zero  = (alu_diff == '0);
            flags_d.carry = (op_a < op_b);
            flags_d.ovf   = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (alu_diff[DATA_W-1] != op_a[DATA_W-1]);
        end else if (mul_done_c) begin
            flags_d.sign  = mul_lo[DATA_W-1];
            flags_d.zero  = (mul_lo == '0);
            flags_d.carry = (mul_hi != '0);
            flags_d.ovf   = (mul_hi != '0);
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) flags_q <= '0;
        else         flags_q <= flags_d;
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0000;
`endif

endmodule
